// File: rtl/tcam_rule_ctrl.sv
// Rule-programming and lookup controller for the 32-rule, 28-bit ternary TCAM.
// Optional power-up row clear is enabled by defining TCAM_INIT_SWEEP_EN.
//
// state | meaning
// INIT  | zeroing all 512 SRAM rows after reset
// IDLE  | waiting for a rule update or a search
// SWEEP | rewriting all 512 rows from the shadow rule set
// SRD   | search read driven on the TCAM bus
// SCAP  | TCAM result sampled into the response registers
// SRSP  | response strobe cycle
module tcam_rule_ctrl #(
    parameter int KEY_W   = 28,
    parameter int N_RULES = 32
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 cfg_valid_i,
    output logic                 cfg_ready_o,
    input  logic [4:0]           cfg_idx_i,
    input  logic [KEY_W-1:0]     cfg_key_i,
    input  logic [KEY_W-1:0]     cfg_mask_i,
    input  logic                 cfg_en_i,
    input  logic                 srch_valid_i,
    output logic                 srch_ready_o,
    input  logic [KEY_W-1:0]     srch_key_i,
    output logic                 rsp_valid_o,
    output logic                 rsp_hit_o,
    output logic [4:0]           rsp_idx_o,
    output logic                 busy_o,
    output logic                 tcam_csb_o,
    output logic                 tcam_web_o,
    output logic [3:0]           tcam_wmask_o,
    output logic [KEY_W-1:0]     tcam_addr_o,
    output logic [N_RULES-1:0]   tcam_wdata_o,
    input  logic [5:0]           tcam_rdata_i
);

    typedef enum logic [2:0] {
        INIT  = 3'd0,
        IDLE  = 3'd1,
        SWEEP = 3'd2,
        SRD   = 3'd3,
        SCAP  = 3'd4,
        SRSP  = 3'd5
    } state_t;

`ifdef TCAM_INIT_SWEEP_EN
    localparam state_t RST_STATE = INIT;
    localparam logic   RST_BUSY  = 1'b1;
`else
    localparam state_t RST_STATE = IDLE;
    localparam logic   RST_BUSY  = 1'b0;
`endif

    state_t               state;
    logic [8:0]           sweep_cnt;
    logic [KEY_W-1:0]     sh_key  [N_RULES];
    logic [KEY_W-1:0]     sh_mask [N_RULES];
    logic [N_RULES-1:0]   sh_valid;
    logic [N_RULES-1:0]   row_bits;
    logic [5:0]           rdata_m1;
    logic                 cfg_acc;
    logic                 srch_acc;

    function automatic logic [6:0] key_chunk(input logic [KEY_W-1:0] v, input logic [1:0] sel);
        logic [6:0] r;
        case (sel)
            2'd0:    r = v[27:21];
            2'd1:    r = v[20:14];
            2'd2:    r = v[13:7];
            default: r = v[6:0];
        endcase
        return r;
    endfunction

    function automatic logic chunk_match(input logic [KEY_W-1:0] key, input logic [KEY_W-1:0] mask,
                                         input logic [8:0] row);
        return (((row[6:0] ^ key_chunk(key, row[8:7])) & key_chunk(mask, row[8:7])) == 7'd0);
    endfunction

    assign cfg_ready_o  = (state == IDLE);
    assign srch_ready_o = (state == IDLE) && !cfg_valid_i;
    assign cfg_acc      = (state == IDLE) && cfg_valid_i;
    assign srch_acc     = (state == IDLE) && srch_valid_i && !cfg_valid_i;
    assign rdata_m1     = tcam_rdata_i - 6'd1;

    // Row 0 is written on the accept edge, so the slot being updated must be
    // taken from the cfg inputs rather than the not-yet-loaded shadow.
    always_comb begin
        row_bits = '0;
        for (int j = 0; j < N_RULES; j++) begin
            if (cfg_acc && (cfg_idx_i == 5'(j)))
                row_bits[j] = cfg_en_i & chunk_match(cfg_key_i, cfg_mask_i, sweep_cnt);
            else
                row_bits[j] = sh_valid[j] & chunk_match(sh_key[j], sh_mask[j], sweep_cnt);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i)
            sh_valid <= '0;
        else if (cfg_acc)
            sh_valid[cfg_idx_i] <= cfg_en_i;
    end

    always_ff @(posedge clk_i) begin
        if (cfg_acc) begin
            sh_key[cfg_idx_i]  <= cfg_key_i;
            sh_mask[cfg_idx_i] <= cfg_mask_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state        <= RST_STATE;
            busy_o       <= RST_BUSY;
            sweep_cnt    <= '0;
            rsp_valid_o  <= 1'b0;
            rsp_hit_o    <= 1'b0;
            rsp_idx_o    <= '0;
            tcam_csb_o   <= 1'b1;
            tcam_web_o   <= 1'b1;
            tcam_wmask_o <= '0;
            tcam_addr_o  <= '0;
            tcam_wdata_o <= '0;
        end else begin
            rsp_valid_o  <= 1'b0;
            tcam_csb_o   <= 1'b1;
            tcam_web_o   <= 1'b1;
            tcam_wmask_o <= '0;
            tcam_addr_o  <= '0;
            tcam_wdata_o <= '0;
            case (state)
                INIT: begin
                    tcam_csb_o   <= 1'b0;
                    tcam_web_o   <= 1'b0;
                    tcam_wmask_o <= 4'hF;
                    tcam_addr_o  <= {19'b0, sweep_cnt};
                    sweep_cnt    <= sweep_cnt + 9'd1;
                    if (sweep_cnt == 9'd511) begin
                        state  <= IDLE;
                        busy_o <= 1'b0;
                    end
                end
                IDLE: begin
                    if (cfg_acc) begin
                        tcam_csb_o   <= 1'b0;
                        tcam_web_o   <= 1'b0;
                        tcam_wmask_o <= 4'hF;
                        tcam_addr_o  <= {19'b0, sweep_cnt};
                        tcam_wdata_o <= row_bits;
                        sweep_cnt    <= sweep_cnt + 9'd1;
                        busy_o       <= 1'b1;
                        state        <= SWEEP;
                    end else if (srch_acc) begin
                        tcam_csb_o  <= 1'b0;
                        tcam_addr_o <= srch_key_i;
                        state       <= SRD;
                    end
                end
                SWEEP: begin
                    // Counter wraps back to 0 once row 511 has been issued.
                    if (sweep_cnt == 9'd0) begin
                        busy_o <= 1'b0;
                        state  <= IDLE;
                    end else begin
                        tcam_csb_o   <= 1'b0;
                        tcam_web_o   <= 1'b0;
                        tcam_wmask_o <= 4'hF;
                        tcam_addr_o  <= {19'b0, sweep_cnt};
                        tcam_wdata_o <= row_bits;
                        sweep_cnt    <= sweep_cnt + 9'd1;
                    end
                end
                SRD: begin
                    state <= SCAP;
                end
                SCAP: begin
                    rsp_valid_o <= 1'b1;
                    rsp_hit_o   <= (tcam_rdata_i != 6'd0);
                    rsp_idx_o   <= (tcam_rdata_i == 6'd0) ? 5'd0 : rdata_m1[4:0];
                    state       <= SRSP;
                end
                SRSP: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tcam_rule_ctrl.sv
// Scoreboard bench for tcam_rule_ctrl: a behavioural SRAM stands in for the TCAM
// black box, and expected lookups come from a rule-list reference model.
module tb_tcam_rule_ctrl;

`ifdef TCAM_INIT_SWEEP_EN
    localparam bit INIT_EN = 1'b1;
`else
    localparam bit INIT_EN = 1'b0;
`endif
    localparam int EXP_INIT = INIT_EN ? 512 : 0;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cfg_valid = 1'b0;
    logic        cfg_ready;
    logic [4:0]  cfg_idx = '0;
    logic [27:0] cfg_key = '0;
    logic [27:0] cfg_mask = '0;
    logic        cfg_en = 1'b0;
    logic        srch_valid = 1'b0;
    logic        srch_ready;
    logic [27:0] srch_key = '0;
    logic        rsp_valid, rsp_hit;
    logic [4:0]  rsp_idx;
    logic        busy;
    logic        csb, web;
    logic [3:0]  wmask;
    logic [27:0] addr;
    logic [31:0] wdata;
    logic [5:0]  rdata = '0;

    tcam_rule_ctrl dut (
        .clk_i(clk), .rst_i(rst),
        .cfg_valid_i(cfg_valid), .cfg_ready_o(cfg_ready), .cfg_idx_i(cfg_idx),
        .cfg_key_i(cfg_key), .cfg_mask_i(cfg_mask), .cfg_en_i(cfg_en),
        .srch_valid_i(srch_valid), .srch_ready_o(srch_ready), .srch_key_i(srch_key),
        .rsp_valid_o(rsp_valid), .rsp_hit_o(rsp_hit), .rsp_idx_o(rsp_idx),
        .busy_o(busy), .tcam_csb_o(csb), .tcam_web_o(web), .tcam_wmask_o(wmask),
        .tcam_addr_o(addr), .tcam_wdata_o(wdata), .tcam_rdata_i(rdata)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int pass_cnt = 0;
    int tot_cnt  = 0;

    task automatic chk(input bit ok, input string nm, input longint act, input longint exp);
        tot_cnt++;
        if (ok) pass_cnt++;
        else $display("FAIL %s: got=%0h expected=%0h (t=%0t)", nm, act, exp, $time);
    endtask

    // Stand-in for the SRAM pair: 512 match-vector rows, synchronous read that
    // ANDs the four chunk rows and priority-encodes the lowest set bit.
    logic [31:0] mem [512];
    initial for (int i = 0; i < 512; i++) mem[i] = '0;

    always @(posedge clk) begin : tcam_model
        logic [31:0] m;
        int p;
        if (rst && !INIT_EN) begin
            for (int i = 0; i < 512; i++) mem[i] <= '0;
        end else if (!csb && !web && wmask == 4'hF) begin
            mem[addr[8:0]] <= wdata;
        end else if (!csb && web) begin
            m = mem[{2'd0, addr[27:21]}] & mem[{2'd1, addr[20:14]}] &
                mem[{2'd2, addr[13:7]}]  & mem[{2'd3, addr[6:0]}];
            p = 0;
            for (int j = 31; j >= 0; j--) if (m[j]) p = j + 1;
            rdata <= 6'(p);
        end
    end

    // Reference rule set.
    logic [27:0] rk [32];
    logic [27:0] rm [32];
    logic        rv [32];

    task automatic clear_model();
        for (int j = 0; j < 32; j++) begin rk[j] = '0; rm[j] = '0; rv[j] = 1'b0; end
    endtask

    function automatic logic [5:0] ref_lookup(input logic [27:0] k);
        for (int j = 0; j < 32; j++)
            if (rv[j] && (((k ^ rk[j]) & rm[j]) == 28'd0)) return 6'(j + 1);
        return 6'd0;
    endfunction

    typedef struct {
        logic       hit;
        logic [4:0] idx;
        int         cyc;
    } exp_t;
    exp_t exp_q[$];

    always @(negedge clk) begin
        exp_t e;
        if (!rst && rsp_valid) begin
            if (exp_q.size() == 0) begin
                chk(1'b0, "rsp_unexpected", 1, 0);
            end else begin
                e = exp_q.pop_front();
                chk(rsp_hit == e.hit, "rsp_hit", rsp_hit, e.hit);
                chk(rsp_idx == e.idx, "rsp_idx", rsp_idx, e.idx);
                chk(cyc == e.cyc, "rsp_latency", cyc, e.cyc);
            end
        end
    end

    task automatic do_search(input logic [27:0] k);
        int n;
        logic [5:0] r;
        exp_t e;
        srch_key   = k;
        srch_valid = 1'b1;
        #1;
        n = 0;
        while (!srch_ready && n < 3000) begin @(negedge clk); n++; end
        if (!srch_ready) begin
            chk(1'b0, "srch_accept_timeout", 0, 1);
            srch_valid = 1'b0;
            return;
        end
        r = ref_lookup(k);
        e.hit = (r != 0);
        e.idx = (r == 0) ? 5'd0 : 5'(r - 6'd1);
        e.cyc = cyc + 3;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        srch_valid = 1'b0;
    endtask

    task automatic do_cfg(input int idx, input logic [27:0] k, input logic [27:0] m,
                          input logic en, input bit with_srch);
        int n, bh, wr, rdy;
        cfg_idx   = 5'(idx);
        cfg_key   = k;
        cfg_mask  = m;
        cfg_en    = en;
        cfg_valid = 1'b1;
        if (with_srch) begin srch_key = k; srch_valid = 1'b1; end
        #1;
        n = 0;
        while (!cfg_ready && n < 3000) begin @(negedge clk); n++; end
        if (!cfg_ready) begin
            chk(1'b0, "cfg_accept_timeout", 0, 1);
            cfg_valid = 1'b0;
            return;
        end
        if (with_srch) chk(srch_ready == 1'b0, "cfg_wins_srch_ready", srch_ready, 0);
        @(posedge clk);
        #1;
        cfg_valid = 1'b0;
        rk[idx] = k; rm[idx] = m; rv[idx] = en;
        bh = 0; wr = 0; rdy = 0;
        for (int i = 1; i <= 512; i++) begin
            @(negedge clk);
            bh  += int'(busy);
            wr  += int'(!csb && !web);
            rdy += int'(cfg_ready | srch_ready);
        end
        @(negedge clk);
        chk(bh == 512, "sweep_busy_cycles", bh, 512);
        chk(wr == 512, "sweep_write_count", wr, 512);
        chk(rdy == 0, "ready_during_sweep", rdy, 0);
        chk(!busy && cfg_ready && srch_ready, "ready_after_sweep",
            {busy, cfg_ready, srch_ready}, 3'b011);
    endtask

    task automatic do_reset();
        int bh, wr, bad, badaddr;
        @(negedge clk);
        rst = 1'b1; cfg_valid = 1'b0; srch_valid = 1'b0;
        repeat (3) @(negedge clk);
        chk(busy == INIT_EN, "rst_busy", busy, INIT_EN);
        chk(cfg_ready == !INIT_EN, "rst_cfg_ready", cfg_ready, !INIT_EN);
        chk(rsp_valid == 0 && rsp_hit == 0 && rsp_idx == 0, "rst_rsp",
            {rsp_valid, rsp_hit, rsp_idx}, 0);
        chk(csb && web && wmask == 0 && addr == 0 && wdata == 0, "rst_tcam_bus",
            {csb, web, wmask, addr[8:0], wdata}, {2'b11, 4'h0, 9'h0, 32'h0});
        clear_model();
        rst = 1'b0;
        bh = int'(busy); wr = 0; bad = 0; badaddr = 0;
        for (int i = 1; i < 600; i++) begin
            @(negedge clk);
            bh += int'(busy);
            if (!csb && !web) begin
                if (wdata != 0) bad++;
                if (addr != 28'(wr)) badaddr++;
                wr++;
            end
        end
        chk(bh == EXP_INIT, "init_busy_cycles", bh, EXP_INIT);
        chk(wr == EXP_INIT, "init_write_count", wr, EXP_INIT);
        chk(bad == 0, "init_write_zero", bad, 0);
        chk(badaddr == 0, "init_write_order", badaddr, 0);
        chk(cfg_ready == 1'b1, "idle_after_init", cfg_ready, 1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        logic [27:0] k, m;
        clear_model();
        do_reset();

        do_search(28'h1234567);
        do_cfg(3, 28'h1234567, 28'hFFFFFFF, 1'b1, 1'b0);
        do_search(28'h1234567);
        do_search(28'h1234566);
        do_cfg(5, 28'h0000000, 28'h0000000, 1'b1, 1'b0);
        do_cfg(2, 28'h0ABCDEF, 28'hFFFFFFF, 1'b1, 1'b0);
        do_search(28'h0ABCDEF);
        do_search(28'h0000001);
        do_search(28'h1234567);
        do_cfg(2, 28'h0ABCDEF, 28'hFFFFFFF, 1'b0, 1'b0);
        do_search(28'h0ABCDEF);
        do_cfg(5, 28'h0, 28'h0, 1'b0, 1'b0);
        do_cfg(3, 28'h0, 28'h0, 1'b0, 1'b0);
        do_cfg(31, 28'h7654321, 28'hFFFFFFF, 1'b1, 1'b0);
        do_search(28'h7654321);
        do_search(28'h7654320);

        do_cfg(0, 28'h1111111, 28'hFFFFFFF, 1'b1, 1'b1);
        do_search(28'h1111111);

        for (int it = 0; it < 60; it++) begin
            if ($urandom_range(0, 3) == 0) begin
                case ($urandom_range(0, 7))
                    0:       m = 28'h0;
                    1, 2:    m = 28'hFFFFFFF;
                    default: m = 28'($urandom) | 28'($urandom);
                endcase
                do_cfg(int'($urandom_range(0, 31)), 28'($urandom), m,
                       ($urandom_range(0, 4) != 0), 1'b0);
            end else begin
                n = int'($urandom_range(0, 31));
                k = (rk[n] & rm[n]) | (28'($urandom) & ~rm[n]);
                if ($urandom_range(0, 2) == 0) k = k ^ (28'd1 << $urandom_range(0, 27));
                if ($urandom_range(0, 3) == 0) k = 28'($urandom);
                do_search(k);
            end
        end

        do_cfg(7, 28'h0F0F0F0, 28'hFFFFFFF, 1'b1, 1'b0);
        do_search(28'h0F0F0F0);
        repeat (6) @(negedge clk);
        cfg_idx = 5'd9; cfg_key = 28'h0F0F0F0; cfg_mask = 28'hFFFFFFF; cfg_en = 1'b1;
        cfg_valid = 1'b1;
        #1;
        n = 0;
        while (!cfg_ready && n < 100) begin @(negedge clk); n++; end
        @(posedge clk);
        #1;
        cfg_valid = 1'b0;
        repeat (200) @(negedge clk);
        do_reset();
        do_search(28'h0F0F0F0);
        do_search(28'h1111111);

        repeat (10) @(negedge clk);
        chk(exp_q.size() == 0, "rsp_missing", exp_q.size(), 0);
        $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
        $finish;
    end

endmodule
